// File: rtl/mem_port_arbiter_rv_if.sv
// Bundle of fetch, load/store and memory-port signals shared by the arbiter and its users.
interface mem_port_arbiter_rv_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_data;
  logic        i_fault;

  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_access;
  logic        d_sign_extend;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_fault;

  logic        m_req;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byte_en;
  logic        m_ready;
  logic [31:0] m_rdata;

  // Requesters and memory: drive requests and memory responses.
  modport master (
    output i_req, i_addr, d_req, d_write, d_addr, d_wdata, d_access, d_sign_extend,
           m_ready, m_rdata,
    input  i_ack, i_data, i_fault, d_ack, d_rdata, d_fault,
           m_req, m_write, m_addr, m_wdata, m_byte_en
  );

  // Arbiter: accepts requests, owns the memory port.
  modport slave (
    input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, d_access, d_sign_extend,
           m_ready, m_rdata,
    output i_ack, i_data, i_fault, d_ack, d_rdata, d_fault,
           m_req, m_write, m_addr, m_wdata, m_byte_en
  );
endinterface

// File: rtl/mem_port_arbiter_rv.sv
// Single memory port shared by instruction fetch and load/store, data has priority.
module mem_port_arbiter_rv #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_rv_if.slave bus
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TIMEOUT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, ACK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_req_q, m_req_d, m_write_q, m_write_d;
  logic [31:0]   m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [3:0]    m_byte_en_q, m_byte_en_d;
  logic          i_ack_q, i_ack_d, i_fault_q, i_fault_d;
  logic [31:0]   i_data_q, i_data_d;
  logic          d_ack_q, d_ack_d, d_fault_q, d_fault_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic [1:0]    lane_q, lane_d, acc_q, acc_d;
  logic          sx_q, sx_d, wr_q, wr_d;

  logic          d_misaligned_c;
  logic [3:0]    d_byte_en_c;
  logic [31:0]   d_wdata_c;
  logic [31:0]   load_c;
  logic [7:0]    load_byte_c;
  logic [15:0]   load_half_c;
  logic [CW-1:0] cnt_inc_c;

  // Alignment check and lane/replication for the pending data request.
  always_comb begin
    d_misaligned_c = 1'b0;
    d_byte_en_c    = 4'b1111;
    d_wdata_c      = bus.d_wdata;
    case (bus.d_access)
      2'd0: begin
        d_byte_en_c = 4'(4'b0001 << bus.d_addr[1:0]);
        d_wdata_c   = {4{bus.d_wdata[7:0]}};
      end
      2'd1: begin
        d_misaligned_c = bus.d_addr[0];
        d_byte_en_c    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
        d_wdata_c      = {2{bus.d_wdata[15:0]}};
      end
      2'd2:    d_misaligned_c = |bus.d_addr[1:0];
      default: d_misaligned_c = 1'b1;
    endcase
  end

  // Lane selection and sign/zero extension of returned load data.
  always_comb begin
    case (lane_q)
      2'd0:    load_byte_c = bus.m_rdata[7:0];
      2'd1:    load_byte_c = bus.m_rdata[15:8];
      2'd2:    load_byte_c = bus.m_rdata[23:16];
      default: load_byte_c = bus.m_rdata[31:24];
    endcase
    load_half_c = lane_q[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    case (acc_q)
      2'd0:    load_c = {{24{sx_q & load_byte_c[7]}}, load_byte_c};
      2'd1:    load_c = {{16{sx_q & load_half_c[15]}}, load_half_c};
      default: load_c = bus.m_rdata;
    endcase
  end

  assign cnt_inc_c = cnt_q + CW'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_req_d     = m_req_q;
    m_write_d   = m_write_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_byte_en_d = m_byte_en_q;
    i_ack_d     = i_ack_q;
    i_data_d    = i_data_q;
    i_fault_d   = i_fault_q;
    d_ack_d     = d_ack_q;
    d_rdata_d   = d_rdata_q;
    d_fault_d   = d_fault_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    sx_d        = sx_q;
    wr_d        = wr_q;
    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          if (d_misaligned_c) begin
            state_d   = ACK;
            d_ack_d   = 1'b1;
            d_fault_d = 1'b1;
            d_rdata_d = 32'h0;
          end else begin
            state_d     = DBUS;
            cnt_d       = '0;
            m_req_d     = 1'b1;
            m_write_d   = bus.d_write;
            m_addr_d    = {bus.d_addr[31:2], 2'b00};
            m_wdata_d   = d_wdata_c;
            m_byte_en_d = d_byte_en_c;
            lane_d      = bus.d_addr[1:0];
            acc_d       = bus.d_access;
            sx_d        = bus.d_sign_extend;
            wr_d        = bus.d_write;
          end
        end else if (bus.i_req) begin
          if (bus.i_addr[1:0] != 2'b00) begin
            state_d   = ACK;
            i_ack_d   = 1'b1;
            i_fault_d = 1'b1;
            i_data_d  = 32'h0;
          end else begin
            state_d     = IBUS;
            cnt_d       = '0;
            m_req_d     = 1'b1;
            m_write_d   = 1'b0;
            m_addr_d    = {bus.i_addr[31:2], 2'b00};
            m_wdata_d   = 32'h0;
            m_byte_en_d = 4'b1111;
          end
        end
      end
      IBUS, DBUS: begin
        if (bus.m_ready) begin
          state_d     = ACK;
          m_req_d     = 1'b0;
          m_write_d   = 1'b0;
          m_byte_en_d = 4'b0000;
          if (state_q == DBUS) begin
            d_ack_d   = 1'b1;
            d_fault_d = 1'b0;
            d_rdata_d = wr_q ? 32'h0 : load_c;
          end else begin
            i_ack_d   = 1'b1;
            i_fault_d = 1'b0;
            i_data_d  = bus.m_rdata;
          end
        end else begin
          cnt_d = cnt_inc_c;
          if ((TIMEOUT != '0) && (cnt_inc_c == TIMEOUT)) begin
            state_d     = ACK;
            m_req_d     = 1'b0;
            m_write_d   = 1'b0;
            m_byte_en_d = 4'b0000;
            if (state_q == DBUS) begin
              d_ack_d   = 1'b1;
              d_fault_d = 1'b1;
              d_rdata_d = 32'h0;
            end else begin
              i_ack_d   = 1'b1;
              i_fault_d = 1'b1;
              i_data_d  = 32'h0;
            end
          end
        end
      end
      ACK: begin
        state_d = IDLE;
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      m_req_q     <= 1'b0;
      m_write_q   <= 1'b0;
      m_addr_q    <= 32'h0;
      m_wdata_q   <= 32'h0;
      m_byte_en_q <= 4'b0000;
      i_ack_q     <= 1'b0;
      i_data_q    <= 32'h0;
      i_fault_q   <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
      d_fault_q   <= 1'b0;
      lane_q      <= 2'b00;
      acc_q       <= 2'b00;
      sx_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m_req_q     <= m_req_d;
      m_write_q   <= m_write_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_byte_en_q <= m_byte_en_d;
      i_ack_q     <= i_ack_d;
      i_data_q    <= i_data_d;
      i_fault_q   <= i_fault_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_fault_q   <= d_fault_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      sx_q        <= sx_d;
      wr_q        <= wr_d;
    end
  end

  assign bus.m_req     = m_req_q;
  assign bus.m_write   = m_write_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_byte_en = m_byte_en_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_data    = i_data_q;
  assign bus.i_fault   = i_fault_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_fault   = d_fault_q;

endmodule

// File: doc/mem_port_arbiter_rv.md
Name: mem_port_arbiter_rv

Overview:
- Shares the core's single memory port between instruction fetch and the load/store path that the RV exec stage drives (orDMemWrite / orDMemAccess / orDMemSignExtend plus the ALU address).
- Arbitrates the two requesters with fixed data priority and generates byte lanes and store data replication.
- Extracts, sign-extends or zero-extends load data.
- Flags misaligned, illegal-size and timed-out accesses as faults.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles without iwMReady before the access is aborted with a fault. 0 disables the timeout. Maximum 65535.

Ports:
- iwClk  input  1  clock; all state changes on the rising edge.
- iwnRst  input  1  asynchronous, active-low reset.
- iwIReq  input  1  fetch request; level, held until orIAck.
- iwIAddr  input  32  fetch address; stable while iwIReq is high.
- orIAck  output  1  one-cycle fetch completion pulse.
- orIData  output  32  fetched word; valid when orIAck=1.
- orIFault  output  1  fetch fault; qualified by orIAck.
- iwDReq  input  1  data request; level, held until orDAck.
- iwDWrite  input  1  1=store, 0=load.
- iwDAddr  input  32  byte address.
- iwDWData  input  32  store data, right-aligned.
- iwDAccess  input  2  0=byte, 1=half, 2=word, 3=illegal.
- iwDSignExtend  input  1  sign-extend load result.
- orDAck  output  1  one-cycle data completion pulse.
- orDRData  output  32  extended load data; valid when orDAck=1.
- orDFault  output  1  data fault; qualified by orDAck.
- orMReq  output  1  memory request.
- orMWrite  output  1  memory write.
- orMAddr  output  32  word address, bits [1:0]=0.
- orMWData  output  32  lane-replicated store data.
- orMByteEn  output  4  byte enables; bit n = byte lane n.
- iwMReady  input  1  memory completes the current access this cycle.
- iwMRData  input  32  read data; valid with iwMReady.

Behaviour:
- Reset:
  - Every output is driven to 0.
  - State goes to IDLE and the timeout counter clears.
  - Reset mid-access drops orMReq immediately; no ack is issued.
- States: IDLE, IBUS, DBUS, ACK.
- IDLE, at each edge:
  - If iwDReq: check alignment first. byte: any address. half: iwDAddr[0]=0. word: iwDAddr[1:0]=0. Access 3 always faults.
    - Misaligned or illegal: go to ACK with orDAck=1, orDFault=1, orDRData=0. No bus cycle.
    - Otherwise: go to DBUS.
  - Else if iwIReq:
    - iwIAddr[1:0]≠0: go to ACK with orIAck=1, orIFault=1, orIData=0.
    - Otherwise: go to IBUS.
  - Data has fixed priority over fetch when both are pending.
- Bus outputs, registered on entry to IBUS/DBUS and held constant throughout:
  - orMReq=1.
  - orMAddr = {addr[31:2], 2'b00}.
  - DBUS: orMWrite=iwDWrite. IBUS: orMWrite=0.
  - Byte enables:
    - byte: orMByteEn = 1<<addr[1:0]; orMWData = {4{wdata[7:0]}}.
    - half: orMByteEn = addr[1] ? 1100 : 0011; orMWData = {2{wdata[15:0]}}.
    - word and fetch: orMByteEn = 1111; orMWData = wdata (fetch: 0).
- IBUS/DBUS, at each edge:
  - iwMReady=1: capture the result, clear orMReq/orMWrite/orMByteEn, go to ACK, pulse the matching ack with fault=0.
    - Load byte: take lane addr[1:0], then sign- or zero-extend from bit 7.
    - Load half: take lane addr[1], then extend from bit 15.
    - Load word: take the full word; iwDSignExtend is ignored.
    - Store: orDRData=0.
  - iwMReady=0: increment the counter. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES, drop orMReq, go to ACK and pulse ack with fault=1 and data=0.
  - The counter clears on entry to any bus state.
- ACK:
  - Lasts exactly one cycle, then returns unconditionally to IDLE.
  - No grant is made in ACK, so a requester that deasserts at the ack edge is never re-served.
  - Acks clear on leaving ACK.
- Data outputs hold their last value outside the ack cycle.
- Latency: minimum 3 edges from request to ack.
  - Edge 1: IDLE grants.
  - Edge 2: iwMReady sampled in the first bus cycle.
  - Edge 3: the ack cycle ends.
  - Fault without a bus cycle: ack in the cycle after the grant edge.
- A request dropped before its ack is illegal stimulus; the arbiter completes the access regardless.
- orIAck and orDAck are never high in the same cycle.

Test Plan:
- Fetch, addr 0x100, memory returns 0x00A00093 with iwMReady in the first bus cycle:
  - orMAddr=0x100, orMByteEn=1111, orMWrite=0.
  - orIAck pulses for one cycle with orIData=0x00A00093 and orIFault=0.
- Load byte signed, addr 0x203, iwMRData=0x80FFFFFF:
  - orMByteEn=1000, orMAddr=0x200.
  - orDRData=0xFFFFFF80.
  - Same access with iwDSignExtend=0 returns 0x00000080.
- Store half, addr 0x102, wdata 0x1234ABCD:
  - orMByteEn=1100, orMWData=0xABCDABCD, orMWrite=1.
  - orDAck with orDFault=0.
- iwIReq and iwDReq rise together:
  - DBUS is served first, then ACK, then IBUS.
  - Order of acks: orDAck, then orIAck; never both high in one cycle.
- Misaligned and illegal accesses:
  - Word load at 0x102: orMReq never rises; orDAck=1, orDFault=1, orDRData=0 one cycle after the grant.
  - iwDAccess=3 at 0x0: same response.
- TIMEOUT_CYCLES=4, iwMReady held at 0:
  - orMReq stays high 4 cycles, then drops; orDAck=1, orDFault=1.
  - Separately, asserting iwnRst=0 during DBUS zeroes all outputs asynchronously and produces no ack.
